// File: rtl/led_arb_pkg.sv
// Shared widths and FSM state type for the LED bank arbiter.
package led_arb_pkg;
  localparam int unsigned LED_W     = 8;
  localparam int unsigned IO_LED_W  = 24;
  localparam int unsigned PATTERN_W = 32;
  localparam int unsigned OWNER_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;
endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin picker: first asserted req at or after pointer, with wrap-around.
module led_rr_picker
  import led_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] pointer,
  output logic               valid,
  output logic [OWNER_W-1:0] index
);
  int unsigned j;

  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(pointer) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        index = OWNER_W'(j);
      end
    end
  end
endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin LED bank arbiter with minimum dwell; registered outputs only.
// Optional urgent requester 0 preemption when LED_ARB_PREEMPT_EN is defined.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned            N_REQ        = 4,
  parameter int unsigned            DWELL_CYCLES = 24000000,
  parameter logic [PATTERN_W-1:0]   IDLE_PATTERN = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           req,
  input  logic [PATTERN_W*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]           gnt,
  output logic [OWNER_W-1:0]         owner,
  output logic                       busy,
  output logic [LED_W-1:0]           LED,
  output logic [IO_LED_W-1:0]        IO_LED
);
  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  arb_state_t           state;
  logic [OWNER_W-1:0]   rr;
  logic [DW-1:0]        dwell;

  logic                 pick_valid;
  logic [OWNER_W-1:0]   pick_idx;
  logic [OWNER_W-1:0]   rr_next;
  logic [N_REQ-1:0]     pick_gnt;
  logic [PATTERN_W-1:0] pick_pat;
  logic [PATTERN_W-1:0] owner_pat;
  logic                 owner_req;

  // Masking with gnt excludes the current owner in HOLD and is a no-op in IDLE.
  led_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (req & ~gnt),
    .pointer (rr),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign owner_req = |(req & gnt);
  assign rr_next   = (pick_idx == OWNER_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    owner_pat = IDLE_PATTERN;
    pick_pat  = IDLE_PATTERN;
    pick_gnt  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner == OWNER_W'(i)) owner_pat = pattern[PATTERN_W*i +: PATTERN_W];
      if (pick_idx == OWNER_W'(i)) begin
        pick_pat    = pattern[PATTERN_W*i +: PATTERN_W];
        pick_gnt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      gnt           <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      {LED, IO_LED} <= IDLE_PATTERN;
      rr            <= '0;
      dwell         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state         <= HOLD;
            gnt           <= pick_gnt;
            owner         <= pick_idx;
            busy          <= 1'b1;
            {LED, IO_LED} <= pick_pat;
            dwell         <= DWELL_LAST;
            rr            <= rr_next;
          end
        end
        HOLD: begin
          {LED, IO_LED} <= owner_pat;
          if (dwell != '0) dwell <= dwell - 1'b1;
`ifdef LED_ARB_PREEMPT_EN
          if (req[0] && owner != '0) begin
            gnt           <= '0;
            gnt[0]        <= 1'b1;
            owner         <= '0;
            {LED, IO_LED} <= pattern[PATTERN_W-1:0];
            dwell         <= DWELL_LAST;
          end else
`endif
          if (!owner_req || dwell == '0) begin
            if (pick_valid) begin
              gnt           <= pick_gnt;
              owner         <= pick_idx;
              {LED, IO_LED} <= pick_pat;
              dwell         <= DWELL_LAST;
              rr            <= rr_next;
            end else if (!owner_req) begin
              state         <= IDLE;
              gnt           <= '0;
              owner         <= '0;
              busy          <= 1'b0;
              {LED, IO_LED} <= IDLE_PATTERN;
            end else begin
              dwell <= DWELL_LAST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed + randomized bench for led_bank_arbiter against an ownership-level reference model.
module tb_led_bank_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam logic [31:0] IDLE_PAT = 32'h0;
`ifdef LED_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] pattern = '0;
  logic [3:0]   gnt;
  logic [2:0]   owner;
  logic         busy;
  logic [7:0]   LED;
  logic [23:0]  IO_LED;

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 idle), edges held since grant, rotation start.
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_rr    = 0;
  logic [31:0] m_pat   = IDLE_PAT;

  led_bank_arbiter #(
    .N_REQ        (N),
    .DWELL_CYCLES (DW),
    .IDLE_PATTERN (IDLE_PAT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .pattern (pattern),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .LED     (LED),
    .IO_LED  (IO_LED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int excl);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_rr + i) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_held  = 1;
    m_rr    = (w + 1) % N;
  endtask

  task automatic model_step();
    int w;
    if (RST) begin
      m_owner = -1; m_held = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      w = pick(req, -1);
      if (w >= 0) model_grant(w);
    end else if (PRE && m_owner != 0 && req[0]) begin
      m_owner = 0; m_held = 1;
    end else if (!req[m_owner]) begin
      w = pick(req, m_owner);
      if (w >= 0) model_grant(w); else m_owner = -1;
    end else if (m_held >= DW) begin
      w = pick(req, m_owner);
      if (w >= 0) model_grant(w); else m_held = 1;
    end else begin
      m_held++;
    end
    m_pat = (m_owner < 0) ? IDLE_PAT : pattern[m_owner*32 +: 32];
  endtask

  task automatic check_model();
    check("gnt",   32'(gnt),   (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
    check("owner", 32'(owner), (m_owner < 0) ? 32'h0 : 32'(m_owner));
    check("busy",  32'(busy),  32'(m_owner >= 0));
    check("leds",  {LED, IO_LED}, m_pat);
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model();
  endtask

  task automatic sync_reset();
    RST = 1'b1;
    req = '0;
    step();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    req = '0;
    step();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_led", {LED, IO_LED}, 32'h0);
    RST = 1'b0;
    step();

    // Single source and hold
    pattern[31:0] = 32'hA5123456;
    req = 4'b0001;
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_led", 32'(LED), 32'hA5);
    check("single_io",  32'(IO_LED), 32'h123456);
    repeat (6) step();
    check("single_hold", 32'(gnt), 32'h1);

    // Live tracking
    pattern[31:0] = 32'h3C00FF11;
    check("track_before", {LED, IO_LED}, 32'hA5123456);
    step();
    check("track_after", {LED, IO_LED}, 32'h3C00FF11);
    check("track_gnt", 32'(gnt), 32'h1);

    // Asynchronous reset mid-hold
    #2 RST = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_led", {LED, IO_LED}, 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    step();
    RST = 1'b0;
    req = 4'b0010;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    check("idle_busy", 32'(busy), 32'h0);

    // Rotation with all requesting
    sync_reset();
    for (int i = 0; i < N; i++) pattern[i*32 +: 32] = 32'h11111111 * (i + 1);
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      check("rot_owner", 32'(owner), 32'((c / 4) % 4));
      check("rot_busy", 32'(busy), 32'h1);
    end

    // Early release: owner 2 drops with req[3] pending, then last owner drops
    sync_reset();
    req = 4'b0100;
    step();
    check("early_own2", 32'(gnt), 32'h4);
    req = 4'b1100;
    step();
    req = 4'b1000;
    step();
    check("early_hand", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    check("early_idle", 32'(busy), 32'h0);
    check("early_led", 32'(LED), 32'h0);

    // Urgent requester 0 against owner 3 at full dwell
    sync_reset();
    req = 4'b1000;
    step();
    check("pre_own3", 32'(gnt), 32'h8);
    req = 4'b1001;
    step();
    check("pre_gnt", 32'(gnt), PRE ? 32'h1 : 32'h8);
    repeat (3) step();
    check("pre_after_dwell", 32'(gnt), 32'h1);

    // Randomized traffic
    sync_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) req[b] = ~req[b];
      if ($urandom_range(3) == 0) pattern[$urandom_range(N - 1)*32 +: 32] = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
